// File: rtl/game_pkg.sv
// Shared types and constants for the game supervisor.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY       = 2'd1,
    WAVE_CLEAR = 2'd2,
    GAME_OVER  = 2'd3
  } game_state_t;

  localparam int unsigned SCORE_MAX = 9999;
  localparam logic [7:0]  KEY_ENTER = 8'h28;
  localparam int unsigned WAVE_MAX  = 15;

endpackage

// File: rtl/bin2bcd.sv
// Combinational 14-bit binary to 4-digit BCD (double-dabble). Input is expected to be <= 9999.
module bin2bcd (
  input  logic [13:0] i_bin,
  output logic [15:0] o_bcd
);

  logic [15:0] w_bcd;

  always_comb begin
    w_bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (w_bcd[4*d +: 4] >= 4'd5) w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
      end
      w_bcd = {w_bcd[14:0], i_bin[i]};
    end
  end

  assign o_bcd = w_bcd;

endmodule

// File: rtl/game_state_ctrl.sv
// Frame-rate game supervisor: score, lives, wave and attract/play/clear/over sequencing.
// Optional HISCORE_EN adds a high-score register and its BCD output.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_INVADERS   = 50,
  parameter int unsigned POINTS_PER_HIT = 10,
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned WAVE_DELAY     = 120,
  parameter int unsigned OVER_HOLD      = 60,
  parameter logic [7:0]  START_KEY      = KEY_ENTER
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [7:0]              keycode,
  input  logic [NUM_INVADERS-1:0] Collision,
  input  logic [NUM_INVADERS-1:0] InvaderOn,
  input  logic                    PlayerHit,
  input  logic                    InvaderLanded,
  output logic [1:0]              GameState,
  output logic [13:0]             Score,
  output logic [15:0]             ScoreBCD,
  output logic [2:0]              Lives,
  output logic [3:0]              Wave,
  output logic                    WaveReset,
  output logic                    GameFreeze
`ifdef HISCORE_EN
  ,
  output logic [15:0]             HiScoreBCD
`endif
);

  localparam int unsigned TMAX = (WAVE_DELAY > OVER_HOLD) ? WAVE_DELAY : OVER_HOLD;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned HW   = $clog2(NUM_INVADERS + 1);
  localparam logic [TW-1:0] TIMER_WAVE_LAST = TW'(WAVE_DELAY - 1);
  localparam logic [TW-1:0] TIMER_HOLD      = TW'(OVER_HOLD);

  game_state_t r_state, w_state_d;
  logic [13:0]   r_score, w_score_d, w_score_add;
  logic [15:0]   r_score_bcd, w_score_bcd;
  logic [2:0]    r_lives, w_lives_d;
  logic [3:0]    r_wave, w_wave_d;
  logic          r_wave_reset, w_wave_reset_d;
  logic          r_freeze;
  logic [TW-1:0] r_timer, w_timer_d;
  logic          r_key_prev, w_key_now, w_start, w_restart;
  logic [NUM_INVADERS-1:0] w_hit_vec;
  logic [HW-1:0] w_hits;
  logic [31:0]   w_sum;

  assign w_key_now = (keycode == START_KEY);
  assign w_start   = w_key_now && !r_key_prev;
  assign w_hit_vec = Collision & InvaderOn;

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < int'(NUM_INVADERS); i++) begin
      w_hits = w_hits + {{(HW-1){1'b0}}, w_hit_vec[i]};
    end
  end

  // 32-bit sum so the worst case (9999 + all hits) saturates instead of wrapping
  assign w_sum       = 32'(r_score) + 32'(w_hits) * POINTS_PER_HIT;
  assign w_score_add = (w_sum > SCORE_MAX) ? 14'(SCORE_MAX) : w_sum[13:0];

  always_comb begin
    w_state_d      = r_state;
    w_score_d      = r_score;
    w_lives_d      = r_lives;
    w_wave_d       = r_wave;
    w_timer_d      = r_timer;
    w_wave_reset_d = 1'b0;
    w_restart      = 1'b0;
    unique case (r_state)
      IDLE: w_restart = w_start;
      PLAY: begin
        w_score_d = w_score_add;
        if (InvaderLanded || (PlayerHit && r_lives <= 3'd1)) begin
          w_state_d = GAME_OVER;
          w_lives_d = '0;
          w_timer_d = '0;
        end else if (PlayerHit) begin
          w_lives_d = r_lives - 3'd1;
        end else if (InvaderOn == '0) begin
          w_state_d = WAVE_CLEAR;
          w_timer_d = '0;
        end
      end
      WAVE_CLEAR: begin
        if (r_timer == TIMER_WAVE_LAST) begin
          w_state_d      = PLAY;
          w_wave_reset_d = 1'b1;
          w_wave_d       = (r_wave >= 4'(WAVE_MAX)) ? 4'(WAVE_MAX) : r_wave + 4'd1;
          w_timer_d      = '0;
        end else begin
          w_timer_d = r_timer + TW'(1);
        end
      end
      GAME_OVER: begin
        if (r_timer == TIMER_HOLD) w_restart = w_start;
        else                       w_timer_d = r_timer + TW'(1);
      end
      default: w_state_d = IDLE;
    endcase
    if (w_restart) begin
      w_state_d      = PLAY;
      w_score_d      = '0;
      w_lives_d      = 3'(START_LIVES);
      w_wave_d       = 4'd1;
      w_wave_reset_d = 1'b1;
      w_timer_d      = '0;
    end
  end

  bin2bcd u_score_bcd (
    .i_bin (w_score_d),
    .o_bcd (w_score_bcd)
  );

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_score      <= '0;
      r_score_bcd  <= '0;
      r_lives      <= 3'(START_LIVES);
      r_wave       <= '0;
      r_wave_reset <= 1'b0;
      r_freeze     <= 1'b1;
      r_timer      <= '0;
      r_key_prev   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_score      <= w_score_d;
      r_score_bcd  <= w_score_bcd;
      r_lives      <= w_lives_d;
      r_wave       <= w_wave_d;
      r_wave_reset <= w_wave_reset_d;
      r_freeze     <= (w_state_d != PLAY);
      r_timer      <= w_timer_d;
      r_key_prev   <= w_key_now;
    end
  end

  assign GameState  = r_state;
  assign Score      = r_score;
  assign ScoreBCD   = r_score_bcd;
  assign Lives      = r_lives;
  assign Wave       = r_wave;
  assign WaveReset  = r_wave_reset;
  assign GameFreeze = r_freeze;

`ifdef HISCORE_EN
  logic        w_enter_over;
  logic [13:0] r_hiscore, w_hiscore_d;
  logic [15:0] r_hiscore_bcd, w_hiscore_bcd;

  // Final score includes hits credited on the game-ending frame
  assign w_enter_over = (r_state == PLAY) && (w_state_d == GAME_OVER);
  assign w_hiscore_d  = (w_enter_over && (w_score_d > r_hiscore)) ? w_score_d : r_hiscore;

  bin2bcd u_hiscore_bcd (
    .i_bin (w_hiscore_d),
    .o_bcd (w_hiscore_bcd)
  );

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_hiscore     <= '0;
      r_hiscore_bcd <= '0;
    end else begin
      r_hiscore     <= w_hiscore_d;
      r_hiscore_bcd <= w_hiscore_bcd;
    end
  end

  assign HiScoreBCD = r_hiscore_bcd;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: a behavioural model queues expected outputs per frame.
module tb_game_state_ctrl;

  localparam int NI = 50;

  logic          frame_clk = 1'b0;
  logic          Reset;
  logic [7:0]    keycode;
  logic [NI-1:0] Collision, InvaderOn;
  logic          PlayerHit, InvaderLanded;
  logic [1:0]    GameState;
  logic [13:0]   Score;
  logic [15:0]   ScoreBCD;
  logic [2:0]    Lives;
  logic [3:0]    Wave;
  logic          WaveReset, GameFreeze;
`ifdef HISCORE_EN
  logic [15:0]   HiScoreBCD;
`endif

  game_state_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .Collision     (Collision),
    .InvaderOn     (InvaderOn),
    .PlayerHit     (PlayerHit),
    .InvaderLanded (InvaderLanded),
    .GameState     (GameState),
    .Score         (Score),
    .ScoreBCD      (ScoreBCD),
    .Lives         (Lives),
    .Wave          (Wave),
    .WaveReset     (WaveReset),
    .GameFreeze    (GameFreeze)
`ifdef HISCORE_EN
    ,
    .HiScoreBCD    (HiScoreBCD)
`endif
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [13:0] sc;
    logic [15:0] bcd;
    logic [2:0]  lv;
    logic [3:0]  wv;
    logic        wr;
    logic        fz;
    logic [15:0] hi;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  int m_st = 0, m_sc = 0, m_lv = 3, m_wv = 0, m_tm = 0, m_hi = 0;
  bit m_wr = 0, m_kp = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_restart();
    m_st = 1; m_sc = 0; m_lv = 3; m_wv = 1; m_wr = 1; m_tm = 0;
  endtask

  task automatic model_step(input logic rst, input logic [7:0] key, input logic [NI-1:0] col,
                            input logic [NI-1:0] inv, input logic ph, input logic il);
    bit st;
    int hits;
    st   = (key == 8'h28) && !m_kp;
    m_wr = 0;
    if (rst) begin
      m_st = 0; m_sc = 0; m_lv = 3; m_wv = 0; m_tm = 0; m_kp = 0; m_hi = 0;
    end else begin
      m_kp = (key == 8'h28);
      case (m_st)
        0: if (st) model_restart();
        1: begin
          hits = $countones(col & inv);
          m_sc = m_sc + hits * 10;
          if (m_sc > 9999) m_sc = 9999;
          if (il || (ph && m_lv == 1)) begin
            m_st = 3; m_lv = 0; m_tm = 0;
            if (m_sc > m_hi) m_hi = m_sc;
          end else if (ph) begin
            m_lv = m_lv - 1;
          end else if (inv == '0) begin
            m_st = 2; m_tm = 0;
          end
        end
        2: begin
          if (m_tm == 119) begin
            m_st = 1; m_wr = 1; m_tm = 0;
            m_wv = (m_wv + 1 > 15) ? 15 : m_wv + 1;
          end else m_tm++;
        end
        default: begin
          if (m_tm == 60) begin
            if (st) model_restart();
          end else m_tm++;
        end
      endcase
    end
  endtask

  task automatic frame(input logic rst, input logic [7:0] key, input logic [NI-1:0] col,
                       input logic [NI-1:0] inv, input logic ph, input logic il);
    exp_t e, o;
    Reset = rst; keycode = key; Collision = col; InvaderOn = inv;
    PlayerHit = ph; InvaderLanded = il;
    model_step(rst, key, col, inv, ph, il);
    e.st = 2'(m_st); e.sc = 14'(m_sc); e.bcd = to_bcd(m_sc); e.lv = 3'(m_lv);
    e.wv = 4'(m_wv); e.wr = m_wr; e.fz = (m_st != 1); e.hi = to_bcd(m_hi);
    sb_q.push_back(e);
    @(posedge frame_clk);
    #1;
    o = sb_q.pop_front();
    check_eq("state", GameState, o.st);
    check_eq("score", Score, o.sc);
    check_eq("score_bcd", ScoreBCD, o.bcd);
    check_eq("lives", Lives, o.lv);
    check_eq("wave", Wave, o.wv);
    check_eq("wave_reset", WaveReset, o.wr);
    check_eq("freeze", GameFreeze, o.fz);
`ifdef HISCORE_EN
    check_eq("hiscore_bcd", HiScoreBCD, o.hi);
`endif
  endtask

  task automatic go(input logic [NI-1:0] col, input logic [NI-1:0] inv, input logic ph,
                    input logic il);
    frame(1'b0, 8'h00, col, inv, ph, il);
  endtask

  task automatic start_game();
    frame(1'b0, 8'h28, '0, '1, 1'b0, 1'b0);
    go('0, '1, 1'b0, 1'b0);
  endtask

  logic [NI-1:0] all1, inv_m, col_b;
  int wr_cnt;

  initial begin
    all1 = '1;
    frame(1'b1, 8'h00, '0, all1, 1'b0, 1'b0);
    frame(1'b1, 8'h00, '0, all1, 1'b0, 1'b0);
    check_eq("rst_state_idle", GameState, 0);
    check_eq("rst_lives", Lives, 3);
    check_eq("rst_freeze", GameFreeze, 1);

    // Held start key: exactly one WaveReset pulse
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      frame(1'b0, 8'h28, '0, all1, 1'b0, 1'b0);
      wr_cnt += int'(WaveReset);
      if (i == 0) begin
        check_eq("start_play", GameState, 1);
        check_eq("start_wave1", Wave, 1);
      end
    end
    check_eq("start_pulse_count", wr_cnt, 1);
    go('0, all1, 1'b0, 1'b0);

    go(50'h7, all1, 1'b0, 1'b0);
    check_eq("score_30", Score, 30);
    check_eq("score_bcd_0030", ScoreBCD, 16'h0030);
    inv_m = all1; inv_m[NI-1] = 1'b0;
    col_b = '0;   col_b[NI-1] = 1'b1;
    go(col_b, inv_m, 1'b0, 1'b0);
    check_eq("dead_hit_ignored", Score, 30);

    for (int i = 0; i < 19; i++) go(all1, all1, 1'b0, 1'b0);
    go((50'd1 << 46) - 50'd1, all1, 1'b0, 1'b0);
    check_eq("score_9990", Score, 9990);
    go(50'h1f, all1, 1'b0, 1'b0);
    check_eq("score_sat", Score, 9999);
    check_eq("score_bcd_9999", ScoreBCD, 16'h9999);
    go(50'h1, all1, 1'b0, 1'b0);
    check_eq("score_stays_sat", Score, 9999);

    go('0, all1, 1'b1, 1'b0);
    go('0, all1, 1'b1, 1'b0);
    check_eq("lives_1", Lives, 1);
    go('0, '0, 1'b1, 1'b0);
    check_eq("last_life_over", GameState, 3);
    check_eq("last_life_zero", Lives, 0);

    // Early start ignored, start after hold honoured
    for (int i = 0; i <= 65; i++) begin
      frame(1'b0, (i == 29 || i == 65) ? 8'h28 : 8'h00, '0, all1, 1'b0, 1'b0);
      if (i == 29) check_eq("early_start_ignored", GameState, 3);
    end
    check_eq("restart_play", GameState, 1);
    check_eq("restart_score0", Score, 0);

    for (int c = 0; c < 17; c++) begin
      go('0, '0, 1'b0, 1'b0);
      if (c == 0) check_eq("enter_wave_clear", GameState, 2);
      for (int t = 0; t < 120; t++) go(all1, all1, 1'b1, 1'b0);
      if (c == 0) begin
        check_eq("wave2", Wave, 2);
        check_eq("wave2_pulse", WaveReset, 1);
        check_eq("clear_no_score", Score, 0);
      end
    end
    check_eq("wave_sat_15", Wave, 15);
    go('0, all1, 1'b0, 1'b1);
    check_eq("landed_over", GameState, 3);

`ifdef HISCORE_EN
    frame(1'b1, 8'h00, '0, all1, 1'b0, 1'b0);
    start_game();
    go((50'd1 << 45) - 50'd1, all1, 1'b0, 1'b1);
    for (int i = 0; i < 61; i++) go('0, all1, 1'b0, 1'b0);
    start_game();
    go((50'd1 << 20) - 50'd1, all1, 1'b0, 1'b1);
    check_eq("hiscore_450", HiScoreBCD, 16'h0450);
`endif

    // Reset in the middle of a wave clear
    frame(1'b1, 8'h00, '0, all1, 1'b0, 1'b0);
    start_game();
    go(50'h3, all1, 1'b0, 1'b0);
    go('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) go('0, all1, 1'b0, 1'b0);
    frame(1'b1, 8'h00, '0, all1, 1'b0, 1'b0);
    check_eq("midreset_state", GameState, 0);
    check_eq("midreset_score", Score, 0);
    check_eq("midreset_wave", Wave, 0);
    check_eq("midreset_lives", Lives, 3);
`ifdef HISCORE_EN
    check_eq("midreset_hiscore", HiScoreBCD, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Frame-rate game supervisor that consumes the invader-collision and invader-alive vectors from the invader/shot stage.
- Keeps score, lives and wave number, and sequences the game through attract, play, wave-clear and game-over.
- Drives the wave-respawn pulse and a global freeze to the player, shot and invader blocks.
- Drives BCD score to the hex drivers and colour mapper.

Parameters:
- NUM_INVADERS, 50, width of Collision/InvaderOn vectors
- POINTS_PER_HIT, 10, binary points added per destroyed invader (1..99)
- START_LIVES, 3, lives at game start (1..7)
- WAVE_DELAY, 120, frames spent in WAVE_CLEAR before respawn
- OVER_HOLD, 60, frames in GAME_OVER before start key is honoured
- START_KEY, 8'h28, USB HID keycode that starts/restarts (Enter)

Ports:
- frame_clk  in  1  frame clock (vsync); sole clock
- Reset  in  1  synchronous, active-high
- keycode  in  8  current HID keycode
- Collision  in  NUM_INVADERS  per-invader hit flags for this frame
- InvaderOn  in  NUM_INVADERS  per-invader alive flags
- PlayerHit  in  1  player struck by enemy fire this frame
- InvaderLanded  in  1  any live invader reached player row
- GameState  out  2  0=IDLE 1=PLAY 2=WAVE_CLEAR 3=GAME_OVER
- Score  out  14  binary score, 0..9999
- ScoreBCD  out  16  4-digit BCD of Score
- Lives  out  3  remaining lives
- Wave  out  4  current wave, 1..15
- WaveReset  out  1  one-frame pulse: respawn invader grid
- GameFreeze  out  1  high when state != PLAY

Behaviour:
- All state and outputs are registered on posedge frame_clk. Response appears on the edge after the inputs.
- Reset values:
  - state IDLE, Score 0, ScoreBCD 0, Lives START_LIVES, Wave 0
  - WaveReset 0, GameFreeze 1, hold timer 0, key_prev 0
- Start edge: start_evt = (keycode==START_KEY) && !key_prev. key_prev <= (keycode==START_KEY) every frame, in every state.
- IDLE:
  - on start_evt -> PLAY; Score<=0, Lives<=START_LIVES, Wave<=1, WaveReset<=1 for that frame.
  - otherwise hold.
- PLAY:
  - hits = popcount(Collision & InvaderOn), 0..NUM_INVADERS.
  - Score <= min(Score + hits*POINTS_PER_HIT, 9999). Intermediate math ≥ 17 bits; saturate, never wrap.
  - Priority, highest first:
    1. InvaderLanded -> GAME_OVER, Lives<=0.
    2. PlayerHit with Lives==1 -> GAME_OVER, Lives<=0.
    3. PlayerHit with Lives>1 -> Lives-1, stay in PLAY.
    4. InvaderOn==0 -> WAVE_CLEAR, timer<=0.
  - Score from the same frame is still credited on any of these transitions.
- WAVE_CLEAR:
  - timer increments each frame.
  - When timer==WAVE_DELAY-1 -> PLAY, WaveReset<=1 for one frame, Wave<=min(Wave+1,15).
  - Collision and PlayerHit are ignored.
- GAME_OVER:
  - timer increments, saturating at OVER_HOLD.
  - start_evt when timer==OVER_HOLD -> behaves as the IDLE start (PLAY, full reinit, WaveReset pulse).
  - start_evt earlier is ignored and is not queued.
- WaveReset is high only on the frame of entry to PLAY. It is never high two consecutive frames.
- ScoreBCD is the registered conversion of the next Score, so both update together.
- Reset mid-game: next edge forces all reset values, regardless of state or pending timers.

Optional Feature:
- Macro HISCORE_EN.
- When defined:
  - Adds output HiScoreBCD[15:0] and an internal 14-bit HiScore register; reset value 0.
  - On entry to GAME_OVER, HiScore <= max(HiScore, final Score).
  - HiScore persists across restarts and is cleared only by Reset.
- When undefined: no port and no register; behaviour otherwise identical.

Decomposition:
- Shared package game_pkg:
  - game_state_t enum (IDLE, PLAY, WAVE_CLEAR, GAME_OVER)
  - SCORE_MAX=9999
  - KEY_ENTER=8'h28
  - WAVE_MAX=15
- One sub-module bin2bcd: combinational 14-bit binary to 4-digit BCD (double-dabble). Instantiated once, twice with HISCORE_EN.

Test Plan:
- Reset, then keycode=8'h28 for 1 frame -> next frame GameState=1, Lives=3, Wave=1, WaveReset=1 for exactly one frame. Holding the key 10 frames yields no second pulse.
- PLAY, Collision has 3 bits set, all in InvaderOn -> Score 0->30, ScoreBCD=16'h0030. A Collision bit with its InvaderOn=0 adds nothing.
- Score=9990, 5 hits -> Score=9999, ScoreBCD=16'h9999. A further hit leaves 9999.
- Lives=1, PlayerHit and InvaderOn==0 in the same frame -> GAME_OVER, Lives=0, no WAVE_CLEAR. Start key at frame 30 is ignored; start at frame ≥60 -> PLAY with Score=0.
- InvaderOn goes to 0 in PLAY -> WAVE_CLEAR for 120 frames, then PLAY with WaveReset=1 and Wave=2. Run 16 clears -> Wave stays 15.
- With HISCORE_EN: game ends at 450, restart, end at 200 -> HiScoreBCD=16'h0450. Assert Reset mid-WAVE_CLEAR -> all outputs at reset values next frame, HiScore=0.
